dmem_port2_arbiter: RTL and testbench
=====================================

# dmem_port2_arbiter

Shares the RAM's second write port (wEn2/addr2/dataIn2) between two background writers, the UART program loader (requester 0) and the SD block-read DMA (requester 1), without stalling the processor. Each requester gets a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains at most one slot per cycle into registered RAM-port outputs. Any write that would hit the same address as a concurrent processor store on port 1 is deferred.

## Interface
Parameters:
- ADDR_W, 12, RAM word-address width
- DATA_W, 32, RAM data width
- CNT_W, 16, per-requester write-counter width

Ports:
- clock  in  1  system clock (the processor clock); all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid  in  1  UART loader has a write
- req0_ready  out  1  slot 0 can accept
- req0_addr  in  ADDR_W  target word address
- req0_data  in  DATA_W  write data
- req1_valid / req1_ready / req1_addr / req1_data: same as above, for SD DMA
- cpu_wen  in  1  processor store on RAM port 1 this cycle
- cpu_addr  in  ADDR_W  processor store address
- ram_wen2  out  1  registered write enable to RAM port 2
- ram_addr2  out  ADDR_W  registered address
- ram_data2  out  DATA_W  registered data
- busy  out  1  either slot occupied or ram_wen2 high
- cnt_clear  in  1  synchronous clear of both counters
- cnt0, cnt1  out  CNT_W  writes issued per requester, saturating

## Operation
- Slot i accepts on an edge where reqi_valid && reqi_ready; it latches addr/data and sets full.
- reqi_ready = !full_i || grant_i. Combinational, so a new write may be accepted on the same edge a slot drains.
- Candidate i is eligible when full_i && !(cpu_wen && cpu_addr == slot_addr_i).
- Grant: if only one candidate is eligible, grant it. If both are eligible, grant the one that is not `last`.
- `last` updates to the granted index only when a grant occurs. A blocked candidate does not move the pointer.
- On a grant edge: ram_wen2<=1, ram_addr2/ram_data2<=slot contents, full_i<=0 (unless refilled the same edge), cnti increments.
- No grant: ram_wen2<=0; ram_addr2/ram_data2 hold their last values.
- Counters saturate at all-ones. cnt_clear wins over an increment on the same edge (result 0).
- Reset values: full0=full1=0, last=1 (requester 0 preferred first), ram_wen2=0, ram_addr2=0, ram_data2=0, cnt0=cnt1=0, busy=0.
- Reset mid-operation: buffered and in-flight writes are discarded and no partial write is issued. Requesters must re-present after reset.
- Data integrity: arbitration never merges or reorders writes within one requester. Ordering between requesters is not guaranteed.

## Timing
- Latency: accept at edge k → ram_wen2 high in cycle k+1 (if eligible and granted) → RAM captures at edge k+2.
- Throughput: one write per cycle aggregate. Each requester gets ≥1 of every 2 grants while both are continuously eligible.
- A processor store to the slot address defers that slot for exactly the cycles where cpu_wen and the address match. The other slot may be granted in the same cycle.
- Back-to-back: with valid held high and no conflicts, a single requester sustains one write per cycle.
- cpu_addr is compared against slot contents at grant time, not at accept time.

## Structure
- Shared package: ADDR_W/DATA_W/CNT_W defaults, requester index constants REQ_UART=0, REQ_SD=1.
- Sub-module `wr_slot`: one-entry buffer (full flag, addr, data, ready logic), instantiated twice.
- Top level holds the eligibility compare, the round-robin pointer, the output registers and the counters.

## Test plan
- Reset: assert reset mid-burst with both slots full → all outputs 0, both ready=1, no ram_wen2 pulse after release.
- Single writer: req0 writes (0x010,0xDEADBEEF) → ram_wen2=1, addr2=0x010, data2=0xDEADBEEF the cycle after acceptance; cnt0=1.
- Fairness: both valid continuously with 4 writes each → grants alternate starting with req0: 0,1,0,1,…; cnt0=cnt1=4 after 8 issue cycles.
- Conflict: slot1 holds addr 0x020, cpu_wen=1 with cpu_addr=0x020 for 3 cycles, slot0 idle → no grant for 3 cycles, grant in cycle 4; `last` stays unchanged while blocked.
- Split conflict: both full, cpu_addr matches slot0 → slot1 granted that cycle, slot0 granted next.
- Saturation/clear: preload cnt0 to 0xFFFE, issue 3 writes → cnt0=0xFFFF. Assert cnt_clear on the same edge as a grant → cnt0=0.

Source files
------------

// File: rtl/dmem_port2_arbiter_pkg.sv
// Shared widths and requester indices for the RAM port-2 write arbiter.
package dmem_port2_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam int REQ_UART = 0;
  localparam int REQ_SD   = 1;

endpackage

// File: rtl/dmem_port2_arbiter_wr_slot.sv
// One-entry holding buffer for a background writer, with a valid/ready handshake.
module wr_slot #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A draining slot can be refilled on the same edge, so ready looks at grant.
  always_comb begin
    in_ready = !full_q || grant;
    full_d   = full_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (grant) begin
      full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      addr_d = in_addr;
      data_d = in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full      = full_q;
  assign slot_addr = addr_q;
  assign slot_data = data_q;

endmodule

// File: rtl/dmem_port2_arbiter.sv
// Round-robin sharing of RAM write port 2 between the UART loader and the SD DMA,
// deferring any slot whose address collides with a processor store on port 1.
module dmem_port2_arbiter
  import dmem_port2_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              ram_wen2,
  output logic [ADDR_W-1:0] ram_addr2,
  output logic [DATA_W-1:0] ram_data2,
  output logic              busy,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic [1:0]        full;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] slot_addr0, slot_addr1;
  logic [DATA_W-1:0] slot_data0, slot_data1;

  logic              last_q, last_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_uart (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (req0_valid),
    .in_ready  (req0_ready),
    .in_addr   (req0_addr),
    .in_data   (req0_data),
    .grant     (grant[REQ_UART]),
    .full      (full[REQ_UART]),
    .slot_addr (slot_addr0),
    .slot_data (slot_data0)
  );

  wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_sd (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (req1_valid),
    .in_ready  (req1_ready),
    .in_addr   (req1_addr),
    .in_data   (req1_data),
    .grant     (grant[REQ_SD]),
    .full      (full[REQ_SD]),
    .slot_addr (slot_addr1),
    .slot_data (slot_data1)
  );

  // The collision check uses the slot contents at grant time, not at accept time.
  always_comb begin
    eligible[REQ_UART] = full[REQ_UART] && !(cpu_wen && (cpu_addr == slot_addr0));
    eligible[REQ_SD]   = full[REQ_SD]   && !(cpu_wen && (cpu_addr == slot_addr1));
    grant = 2'b00;
    if (eligible[REQ_UART] && eligible[REQ_SD]) begin
      grant = (last_q == 1'(REQ_SD)) ? 2'b01 : 2'b10;
    end else if (eligible[REQ_UART]) begin
      grant = 2'b01;
    end else if (eligible[REQ_SD]) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    wen_d  = |grant;
    addr_d = addr_q;
    data_d = data_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant[REQ_UART]) begin
      last_d = 1'(REQ_UART);
      addr_d = slot_addr0;
      data_d = slot_data0;
      if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
    end else if (grant[REQ_SD]) begin
      last_d = 1'(REQ_SD);
      addr_d = slot_addr1;
      data_d = slot_data1;
      if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
    end
    if (cnt_clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  // last resets to the SD index so the UART loader wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'(REQ_SD);
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      last_q <= last_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign ram_wen2  = wen_q;
  assign ram_addr2 = addr_q;
  assign ram_data2 = data_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign busy      = (|full) || wen_q;

endmodule

// File: tb/tb_dmem_port2_arbiter.sv
// Directed bench for dmem_port2_arbiter: a write scoreboard checks every port-2 write,
// plus explicit checks of timing, readiness, counters and reset behaviour.
module tb_dmem_port2_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  // A narrow counter lets saturation be reached in a few hundred cycles.
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req0_valid = 1'b0;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req1_valid = 1'b0;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              cpu_wen = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              ram_wen2;
  logic [ADDR_W-1:0] ram_addr2;
  logic [DATA_W-1:0] ram_data2;
  logic              busy;
  logic              cnt_clear = 1'b0;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  int  n_assert = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  dmem_port2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .ram_wen2   (ram_wen2),
    .ram_addr2  (ram_addr2),
    .ram_data2  (ram_data2),
    .busy       (busy),
    .cnt_clear  (cnt_clear),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample just after the edge, and score any port-2 write.
  task automatic step();
    wr_t e;
    @(posedge clock);
    #1;
    if (ram_wen2 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_wen2", 64'(ram_wen2), 64'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_addr", 64'(ram_addr2), 64'(e.addr));
        checkOutput("sb_data", 64'(ram_data2), 64'(e.data));
      end
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0, input logic v1,
                               input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
  endtask

  // Drive one cycle; accepted writes are queued in requester order when push_en is set.
  task automatic driveCycle(input logic v0, input logic [ADDR_W-1:0] a0,
                            input logic [DATA_W-1:0] d0, input logic v1,
                            input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                            input bit push_en, output bit acc0, output bit acc1);
    wr_t e;
    applyStimulus(v0, a0, d0, v1, a1, d1);
    #1;
    acc0 = (req0_valid && req0_ready);
    acc1 = (req1_valid && req1_ready);
    if (push_en && acc0) begin
      e.addr = a0; e.data = d0; exp_q.push_back(e);
    end
    if (push_en && acc1) begin
      e.addr = a1; e.data = d1; exp_q.push_back(e);
    end
    step();
  endtask

  task automatic pushExp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    cpu_wen   = 1'b0;
    cnt_clear = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    for (int i = 0; i < n; i++) driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
  endtask

  initial begin
    bit a0, a1;
    int i0, i1;

    $display("[TB] reset values");
    #2;
    doReset();
    checkOutput("rst_wen2", 64'(ram_wen2), 64'h0);
    checkOutput("rst_addr2", 64'(ram_addr2), 64'h0);
    checkOutput("rst_data2", 64'(ram_data2), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_cnt0", 64'(cnt0), 64'h0);
    checkOutput("rst_cnt1", 64'(cnt1), 64'h0);
    checkOutput("rst_ready0", 64'(req0_ready), 64'h1);
    checkOutput("rst_ready1", 64'(req1_ready), 64'h1);

    $display("[TB] single writer");
    driveCycle(1'b1, 12'h010, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1, a0, a1);
    checkOutput("single_accept", 64'(a0), 64'h1);
    checkOutput("single_wen_early", 64'(ram_wen2), 64'h0);
    checkOutput("single_busy_held", 64'(busy), 64'h1);
    driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
    checkOutput("single_wen", 64'(ram_wen2), 64'h1);
    checkOutput("single_addr", 64'(ram_addr2), 64'h010);
    checkOutput("single_data", 64'(ram_data2), 64'hDEADBEEF);
    checkOutput("single_cnt0", 64'(cnt0), 64'h1);
    idle(1);
    checkOutput("single_wen_drop", 64'(ram_wen2), 64'h0);
    checkOutput("single_addr_hold", 64'(ram_addr2), 64'h010);
    checkOutput("single_busy_idle", 64'(busy), 64'h0);

    $display("[TB] fairness");
    doReset();
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 12; c++) begin
      driveCycle(i0 < 4, 12'(12'h100 + i0), 32'hA000_0000 | i0,
                 i1 < 4, 12'(12'h200 + i1), 32'hB000_0000 | i1, 1'b1, a0, a1);
      if (a0) i0++;
      if (a1) i1++;
    end
    checkOutput("fair_cnt0", 64'(cnt0), 64'h4);
    checkOutput("fair_cnt1", 64'(cnt1), 64'h4);
    checkOutput("fair_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] address conflict");
    doReset();
    driveCycle(1'b0, '0, '0, 1'b1, 12'h020, 32'h1111_2222, 1'b1, a0, a1);
    cpu_wen  = 1'b1;
    cpu_addr = 12'h020;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("conf_ready1_blocked", 64'(req1_ready), 64'h0);
      driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
      checkOutput("conf_no_grant", 64'(ram_wen2), 64'h0);
    end
    cpu_wen = 1'b0;
    #1;
    checkOutput("conf_ready1_free", 64'(req1_ready), 64'h1);
    driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
    checkOutput("conf_grant_wen", 64'(ram_wen2), 64'h1);
    checkOutput("conf_grant_addr", 64'(ram_addr2), 64'h020);
    checkOutput("conf_cnt1", 64'(cnt1), 64'h1);

    $display("[TB] split conflict");
    doReset();
    pushExp(12'h040, 32'hC1C1_C1C1);
    pushExp(12'h030, 32'hC0C0_C0C0);
    driveCycle(1'b1, 12'h030, 32'hC0C0_C0C0, 1'b1, 12'h040, 32'hC1C1_C1C1, 1'b0, a0, a1);
    cpu_wen  = 1'b1;
    cpu_addr = 12'h030;
    driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
    checkOutput("split_first_addr", 64'(ram_addr2), 64'h040);
    cpu_wen = 1'b0;
    driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
    checkOutput("split_second_wen", 64'(ram_wen2), 64'h1);
    checkOutput("split_second_addr", 64'(ram_addr2), 64'h030);
    checkOutput("split_cnts", 64'({cnt0, cnt1}), 64'h0101);

    $display("[TB] saturation and clear");
    doReset();
    for (int k = 0; k < 254; k++) begin
      driveCycle(1'b1, 12'(k), 32'h5A00_0000 | k, 1'b0, '0, '0, 1'b1, a0, a1);
    end
    idle(1);
    checkOutput("sat_preload", 64'(cnt0), 64'hFE);
    for (int k = 0; k < 3; k++) begin
      driveCycle(1'b1, 12'(12'h300 + k), 32'h6B00_0000 | k, 1'b0, '0, '0, 1'b1, a0, a1);
    end
    idle(1);
    checkOutput("sat_top", 64'(cnt0), 64'hFF);
    driveCycle(1'b1, 12'h3F0, 32'h7C00_0000, 1'b0, '0, '0, 1'b1, a0, a1);
    cnt_clear = 1'b1;
    driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, a0, a1);
    cnt_clear = 1'b0;
    checkOutput("clear_wen", 64'(ram_wen2), 64'h1);
    checkOutput("clear_beats_inc", 64'(cnt0), 64'h0);
    checkOutput("clear_cnt1", 64'(cnt1), 64'h0);

    $display("[TB] reset mid-burst");
    doReset();
    driveCycle(1'b1, 12'h050, 32'hE0E0_0000, 1'b1, 12'h060, 32'hE1E1_0000, 1'b1, a0, a1);
    driveCycle(1'b1, 12'h051, 32'hE0E0_0001, 1'b1, 12'h061, 32'hE1E1_0001, 1'b1, a0, a1);
    checkOutput("mid_wen_before", 64'(ram_wen2), 64'h1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("mid_rst_wen2", 64'(ram_wen2), 64'h0);
    checkOutput("mid_rst_addr2", 64'(ram_addr2), 64'h0);
    checkOutput("mid_rst_data2", 64'(ram_data2), 64'h0);
    checkOutput("mid_rst_busy", 64'(busy), 64'h0);
    checkOutput("mid_rst_ready", 64'({req0_ready, req1_ready}), 64'h3);
    checkOutput("mid_rst_cnts", 64'({cnt0, cnt1}), 64'h0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      checkOutput("mid_no_pulse", 64'(ram_wen2), 64'h0);
    end
    checkOutput("mid_busy_after", 64'(busy), 64'h0);
    checkOutput("end_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
